// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the EX stage: one shift-add or
// restoring-divide step per cycle, with sign correction applied in a final cycle.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            div_by_zero
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_t;

    state_t            stateR;
    state_t            stateNxtS;
    logic [CW-1:0]     cntR;
    // Upper half holds the partial product / remainder, lower half the
    // multiplier / quotient as it shifts.
    logic [2*XLEN-1:0] accR;
    logic [2*XLEN-1:0] accStepS;
    logic [XLEN-1:0]   opndR;
    logic [XLEN-1:0]   origAR;
    logic              isDivR;
    logic              negQR;
    logic              negRR;
    logic              bZeroR;

    logic              isSignedS;
    logic              acceptS;
    logic [XLEN-1:0]   absAS;
    logic [XLEN-1:0]   absBS;
    logic [XLEN:0]     mulSumS;
    logic [XLEN:0]     divShS;
    logic [XLEN:0]     divDiffS;
    logic              divGeS;
    logic [2*XLEN-1:0] prodS;
    logic [XLEN-1:0]   quoS;
    logic [XLEN-1:0]   remS;
    logic [XLEN-1:0]   resHiS;
    logic [XLEN-1:0]   resLoS;
    logic              resDbzS;

    // Operand magnitudes; only the signed ops (op[0]==0) look at sign bits.
    always_comb begin
        isSignedS = ~op[0];
        acceptS   = start & ~flush;
        if (isSignedS && a[XLEN-1]) begin
            absAS = ~a + XLEN'(1);
        end else begin
            absAS = a;
        end
        if (isSignedS && b[XLEN-1]) begin
            absBS = ~b + XLEN'(1);
        end else begin
            absBS = b;
        end
    end

    // Next-state logic; flush always returns to IDLE and beats a start.
    always_comb begin
        stateNxtS = stateR;
        case (stateR)
            IDLE: begin
                if (acceptS) begin
                    stateNxtS = RUN;
                end else begin
                    stateNxtS = IDLE;
                end
            end
            RUN: begin
                if (flush) begin
                    stateNxtS = IDLE;
                end else if (cntR == LAST_CNT) begin
                    stateNxtS = FIX;
                end else begin
                    stateNxtS = RUN;
                end
            end
            FIX:     stateNxtS = IDLE;
            default: stateNxtS = IDLE;
        endcase
    end

    // One multiply or divide iteration on the accumulator.
    always_comb begin
        mulSumS  = {1'b0, accR[2*XLEN-1:XLEN]} + (accR[0] ? {1'b0, opndR} : {(XLEN+1){1'b0}});
        divShS   = {accR[2*XLEN-1:XLEN], accR[XLEN-1]};
        divGeS   = (divShS >= {1'b0, opndR});
        divDiffS = divShS - {1'b0, opndR};
        if (isDivR) begin
            if (divGeS) begin
                accStepS = {divDiffS[XLEN-1:0], accR[XLEN-2:0], 1'b1};
            end else begin
                accStepS = {divShS[XLEN-1:0], accR[XLEN-2:0], 1'b0};
            end
        end else begin
            accStepS = {mulSumS, accR[XLEN-1:1]};
        end
    end

    // Sign correction and divide-by-zero override for the FIX write.
    always_comb begin
        prodS   = negQR ? (~accR + (2*XLEN)'(1)) : accR;
        quoS    = accR[XLEN-1:0];
        remS    = accR[2*XLEN-1:XLEN];
        resDbzS = 1'b0;
        if (isDivR) begin
            if (bZeroR) begin
                resHiS  = origAR;
                resLoS  = {XLEN{1'b1}};
                resDbzS = 1'b1;
            end else begin
                resHiS = negRR ? (~remS + XLEN'(1)) : remS;
                resLoS = negQR ? (~quoS + XLEN'(1)) : quoS;
            end
        end else begin
            resHiS = prodS[2*XLEN-1:XLEN];
            resLoS = prodS[XLEN-1:0];
        end
    end

    // State register with busy decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateR <= IDLE;
            busy   <= 1'b0;
        end else begin
            stateR <= stateNxtS;
            busy   <= (stateNxtS != IDLE);
        end
    end

    // Operand latch and iteration datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cntR   <= '0;
            accR   <= '0;
            opndR  <= '0;
            origAR <= '0;
            isDivR <= 1'b0;
            negQR  <= 1'b0;
            negRR  <= 1'b0;
            bZeroR <= 1'b0;
        end else begin
            case (stateR)
                IDLE: begin
                    if (acceptS) begin
                        cntR   <= '0;
                        isDivR <= op[1];
                        negQR  <= isSignedS & (a[XLEN-1] ^ b[XLEN-1]);
                        negRR  <= isSignedS & a[XLEN-1];
                        bZeroR <= (b == {XLEN{1'b0}});
                        origAR <= a;
                        if (op[1]) begin
                            opndR <= absBS;
                            accR  <= {{XLEN{1'b0}}, absAS};
                        end else begin
                            opndR <= absAS;
                            accR  <= {{XLEN{1'b0}}, absBS};
                        end
                    end
                end
                RUN: begin
                    if (!flush) begin
                        accR <= accStepS;
                        cntR <= cntR + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers; only a non-flushed FIX cycle writes them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stateR == FIX && !flush) begin
                hi          <= resHiS;
                lo          <= resLoS;
                div_by_zero <= resDbzS;
                done        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes model results, a monitor
// pops and compares them on every done pulse.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          nCmp = 0;
    int          nFail = 0;
    int          cyc = 0;
    logic [31:0] modelHi = '0;
    logic [31:0] modelLo = '0;
    logic [31:0] pendHi = '0;
    logic [31:0] pendLo = '0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference results straight from integer arithmetic.
    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] h, output logic [31:0] l, output logic z);
        longint      sx;
        longint      sy;
        longint      p;
        logic [63:0] up;
        z = 1'b0;
        case (o)
            2'b00: begin
                sx = $signed(x);
                sy = $signed(y);
                p = sx * sy;
                {h, l} = p;
            end
            2'b01: begin
                up = {32'd0, x} * {32'd0, y};
                {h, l} = up;
            end
            default: begin
                if (y == 32'd0) begin
                    h = x;
                    l = 32'hFFFF_FFFF;
                    z = 1'b1;
                end else if (o == 2'b10) begin
                    sx = $signed(x);
                    sy = $signed(y);
                    p = sx / sy;
                    l = p[31:0];
                    p = sx % sy;
                    h = p[31:0];
                end else begin
                    l = x / y;
                    h = x % y;
                end
            end
        endcase
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        model(o, x, y, e.hi, e.lo, e.dbz);
        e.cyc = cyc + 34;
        sb.push_back(e);
        pendHi = e.hi;
        pendLo = e.lo;
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 2'($urandom_range(0, 3));
    endtask

    task automatic waitDone(input string name);
        bit seen = 0;
        bit busyOk = 1;
        if (!busy) busyOk = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
            else if (!busy) busyOk = 0;
        end
        check({name, "_busy_run"}, 64'(busyOk), 64'd1);
        if (!seen) begin
            check({name, "_timeout"}, 64'd0, 64'd1);
        end else begin
            modelHi = pendHi;
            modelLo = pendLo;
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("hi", 64'(hi), 64'(e.hi));
                check("lo", 64'(lo), 64'(e.lo));
                check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                check("latency", 64'(cyc), 64'(e.cyc));
                check("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        #1;
        check("reset_outputs", {busy, done, div_by_zero, hi, lo}, 67'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        issue(2'b00, 32'hFFFF_FFFD, 32'd7);
        waitDone("mult_neg3x7");
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone("multu_max");
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        waitDone("div_neg7by2");
        issue(2'b11, 32'd100, 32'd0);
        waitDone("divu_by0");
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone("div_ovf");
        issue(2'b10, 32'd55, 32'd0);
        waitDone("div_by0");

        // Start pulses while busy must be ignored.
        issue(2'b01, 32'd123, 32'd456);
        start = 1'b1;
        op = 2'b11;
        a = 32'd9;
        b = 32'd3;
        repeat (5) @(negedge clk);
        start = 1'b0;
        waitDone("start_while_busy");

        // Flush at cycle 10 of a divide.
        issue(2'b11, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        void'(sb.pop_back());
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hi", 64'(hi), 64'(modelHi));
        check("flush_lo", 64'(lo), 64'(modelLo));
        repeat (40) @(negedge clk);

        // Flush beats start in IDLE.
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_vs_start_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);

        // Reset mid-run.
        issue(2'b01, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (14) @(negedge clk);
        void'(sb.pop_back());
        reset = 1'b1;
        #1;
        check("midrun_reset_outputs", {busy, done, div_by_zero, hi, lo}, 67'd0);
        @(negedge clk);
        reset = 1'b0;
        modelHi = '0;
        modelLo = '0;
        repeat (3) @(negedge clk);
        issue(2'b01, 32'd6, 32'd7);
        waitDone("multu_6x7_after_reset");

        // Randomized operations, mostly back-to-back.
        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = 32'($urandom_range(0, 1000)); rb = 32'($urandom_range(1, 50)); end
                3: rb = 32'($signed(-$urandom_range(1, 20)));
                default: begin end
            endcase
            issue(ro, ra, rb);
            waitDone("random");
            if ((n % 5) == 4) repeat (2) @(negedge clk);
        end

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) check("scoreboard_drain", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand width; the iteration count equals XLEN.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 a  input  XLEN  rs operand; multiplicand or dividend.
REQ-007 b  input  XLEN  rt operand; multiplier or divisor.
REQ-008 flush  input  1  squash the in-flight operation; driven by EX branch-taken.
REQ-009 busy  output  1  operation in flight; the EX stage stalls on mfhi/mflo/new mult-div while high.
REQ-010 done  output  1  one-cycle pulse; the result was written to hi/lo at the edge that raised it.
REQ-011 hi  output  XLEN  product upper half, or remainder.
REQ-012 lo  output  XLEN  product lower half, or quotient.
REQ-013 div_by_zero  output  1  last completed divide had b==0; valid while done is high and held until the next completion.

Function
REQ-014 FSM has three states, IDLE, RUN and FIX, encoded as one state register.
REQ-015 IDLE: if start=1 and flush=0 at an edge, latch op, |a|, |b| and the result signs, clear the iteration counter, and go to RUN.
REQ-016 Signs are used only for op 00 and 10, i.e. the signed ops; unsigned ops treat operands as magnitudes.
REQ-017 RUN: perform one iteration per cycle for XLEN cycles, using the counter over 0..XLEN-1.
REQ-018 RUN iteration, multiply: shift-add radix-2 into a 2*XLEN accumulator.
REQ-019 RUN iteration, divide: restoring radix-2 division.
REQ-020 RUN exit: when the counter reaches XLEN-1, go to FIX.
REQ-021 FIX: apply sign correction, write hi/lo, raise done for exactly one cycle, then return to IDLE.
REQ-022 Latency: with start accepted at edge E0, hi/lo/done update at edge E(XLEN+1), i.e. E33 at default.
REQ-023 busy is 1 from after E0 up to E(XLEN+1), and 0 in the cycle where done is 1.
REQ-024 start while busy=1 is ignored; inputs a, b and op are not re-sampled.
REQ-025 start is accepted in the same cycle that done=1 (the FSM is in IDLE), giving back-to-back operations.
REQ-026 Signed multiply gives the full 2*XLEN two's-complement product {hi,lo}.
REQ-027 Unsigned multiply gives the full unsigned product {hi,lo}.
REQ-028 Signed divide truncates the quotient toward zero into lo; the remainder in hi takes the dividend's sign.
REQ-029 b==0, any divide: lo=all ones, hi=a (original dividend), div_by_zero=1.
REQ-030 b==0 takes full latency.
REQ-031 Signed overflow (a=0x80000000, b=0xFFFFFFFF): lo=0x80000000, hi=0, div_by_zero=0.
REQ-032 Multiply ops complete with div_by_zero=0.
REQ-033 flush=1 in RUN or FIX: next state IDLE, hi/lo/div_by_zero unchanged, done stays 0.
REQ-034 flush=1 together with start in IDLE: flush wins and no operation starts.
REQ-035 hi/lo change only at the FIX edge or at reset.

Reset
REQ-036 reset=1 asynchronously forces IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, counter=0.
REQ-037 reset asserted mid-RUN aborts the operation with no done pulse.
REQ-038 after reset deasserts, the first accepted start behaves per REQ-015.

Verification
REQ-039 MULT a=0xFFFFFFFD (-3), b=7 -> done at E33, {hi,lo}=0xFFFFFFFF_FFFFFFEB, busy high cycles 1..32.
REQ-040 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-041 DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100, div_by_zero=1.
REQ-042 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
REQ-043 DIVU 100/7 started, flush at cycle 10 -> no done, hi/lo keep prior values, busy=0 next cycle; a new start at the done cycle of a prior op is accepted and completes 33 edges later.
REQ-044 reset pulsed at cycle 15 of MULTU -> all outputs 0 immediately, no done; a following MULTU 6*7 yields lo=42, hi=0.
